// File: rtl/uart_script_engine.sv
// Byte-script UART generator/checker: plays tx script into uart_tx, scores uart_rx against expected script.
// Latency: start -> first uart_tx_valid one cycle later when uart_tx_ready is already high.
// Backpressure: waits on uart_tx_ready before every byte; rx side is never stalled and simply scores.
module uart_script_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int TX_DEPTH   = 16,
    parameter int EXP_DEPTH  = 16,
    parameter int GAP_CYCLES = 0,
    parameter int TIMEOUT    = 1000000,
    parameter int CNT_W      = 16,
    localparam int TAW = $clog2(TX_DEPTH),
    localparam int EAW = $clog2(EXP_DEPTH),
    localparam int AW  = (TAW > EAW) ? TAW : EAW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [TAW:0]          tx_len,
    input  logic [EAW:0]          exp_len,
    input  logic                  start,
    input  logic                  uart_tx_ready,
    output logic                  uart_tx_valid,
    output logic [DATA_WIDTH-1:0] uart_tx_data,
    input  logic                  uart_rx_valid,
    input  logic [DATA_WIDTH-1:0] uart_rx_data,
    input  logic                  uart_rx_err,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [CNT_W-1:0]      err_count,
    output logic [CNT_W-1:0]      rx_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GAP     = 3'd1;
    localparam logic [2:0] S_SEND    = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_WAITRDY = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam int TMW = $clog2(TIMEOUT + 1);
    localparam int GW  = $clog2(GAP_CYCLES + 2);
    localparam logic [TAW:0]    TX_MAX   = (TAW+1)'(TX_DEPTH);
    localparam logic [EAW:0]    EXP_MAX  = (EAW+1)'(EXP_DEPTH);
    localparam logic [TMW-1:0]  TMO_LAST = TMW'(TIMEOUT - 1);
    localparam logic [GW-1:0]   GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] tx_mem  [TX_DEPTH];
    logic [DATA_WIDTH-1:0] exp_mem [EXP_DEPTH];
    logic [TAW:0]          idx;
    logic [TAW:0]          tx_len_q;
    logic [EAW:0]          exp_len_q;
    logic                  hold_cnt;
    logic [GW-1:0]         gap_cnt;
    logic [TMW-1:0]        tmo_cnt;

    logic                  start_ok;
    logic [TAW:0]          tx_len_c;
    logic [EAW:0]          exp_len_c;
    logic [CNT_W-1:0]      exp_len_w;
    logic                  rx_miss;
    logic [CNT_W:0]        err_sum;
    logic [CNT_W-1:0]      err_nxt;
    logic [CNT_W-1:0]      rx_nxt;
    logic                  tmo_hit;

    assign busy          = (state != S_IDLE) && (state != S_DONE);
    assign start_ok      = start && !busy;
    assign tx_len_c      = (tx_len > TX_MAX) ? TX_MAX : tx_len;
    assign exp_len_c     = (exp_len > EXP_MAX) ? EXP_MAX : exp_len;
    assign exp_len_w     = CNT_W'(exp_len_q);
    assign uart_tx_valid = (state == S_SEND) && uart_tx_ready;
    assign uart_tx_data  = uart_tx_valid ? tx_mem[idx[TAW-1:0]] : '0;

    // Beyond exp_len every byte is an extra; the memory index is only meaningful below it.
    assign rx_miss = uart_rx_valid &&
                     ((rx_count >= exp_len_w) || (uart_rx_data != exp_mem[rx_count[EAW-1:0]]));
    assign err_sum = {1'b0, err_count} + (CNT_W+1)'(rx_miss) + (CNT_W+1)'(uart_rx_err);
    assign err_nxt = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    assign rx_nxt  = (uart_rx_valid && (rx_count != '1)) ? rx_count + CNT_W'(1) : rx_count;
    assign tmo_hit = busy && !uart_tx_valid && !uart_rx_valid && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            if (!wr_sel && ({1'b0, wr_addr} < (AW+1)'(TX_DEPTH)))
                tx_mem[wr_addr[TAW-1:0]] <= wr_data;
            if (wr_sel && ({1'b0, wr_addr} < (AW+1)'(EXP_DEPTH)))
                exp_mem[wr_addr[EAW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            tx_len_q  <= '0;
            exp_len_q <= '0;
            hold_cnt  <= 1'b0;
            gap_cnt   <= '0;
            tmo_cnt   <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            err_count <= '0;
            rx_count  <= '0;
        end else begin
            if (busy) begin
                err_count <= err_nxt;
                rx_count  <= rx_nxt;
                tmo_cnt   <= (uart_tx_valid || uart_rx_valid) ? '0 : tmo_cnt + TMW'(1);
            end
            if (start_ok) begin
                tx_len_q  <= tx_len_c;
                exp_len_q <= exp_len_c;
                idx       <= '0;
                tmo_cnt   <= '0;
                err_count <= '0;
                rx_count  <= '0;
                done      <= 1'b0;
                pass      <= 1'b0;
                timeout   <= 1'b0;
                state     <= (tx_len_c == '0) ? S_DRAIN : S_SEND;
            end else if (tmo_hit) begin
                // Abort wherever we are; an in-flight tx byte is simply abandoned.
                state   <= S_DONE;
                done    <= 1'b1;
                timeout <= 1'b1;
                pass    <= 1'b0;
            end else begin
                case (state)
                    S_SEND: if (uart_tx_ready) begin
                        idx      <= idx + (TAW+1)'(1);
                        hold_cnt <= 1'b0;
                        state    <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (hold_cnt) state <= S_WAITRDY;
                        hold_cnt <= 1'b1;
                    end
                    S_WAITRDY: if (uart_tx_ready) begin
                        gap_cnt <= '0;
                        if (idx == tx_len_q)     state <= S_DRAIN;
                        else if (GAP_CYCLES == 0) state <= S_SEND;
                        else                     state <= S_GAP;
                    end
                    S_GAP: begin
                        if (gap_cnt == GAP_LAST) state <= S_SEND;
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                    S_DRAIN: if (rx_count >= exp_len_w) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        pass  <= (err_nxt == '0) && (rx_nxt == exp_len_w);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_script_engine.sv
// Bench for uart_script_engine: tx loopback BFM, scoreboard queues for tx bytes and end-of-run results.
module tb_uart_script_engine;

    localparam int TXD = 16;
    localparam int EXD = 16;
    localparam int GAP = 2;
    localparam int TMO = 200;

    typedef struct packed {
        logic [15:0] err;
        logic [15:0] rx;
        logic        pass;
        logic        tmo;
    } res_t;

    logic        clk = 1'b0;
    logic        rst, wr_en, wr_sel, start;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  tx_len, exp_len;
    logic        uart_tx_ready, uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_rx_valid, uart_rx_err;
    logic [7:0]  uart_rx_data;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count, rx_count;

    int   checks = 0;
    int   errors = 0;
    logic [7:0] tx_q[$];
    res_t       res_q[$];
    logic [7:0] s_tx[16], s_exp[16], s_mask[16];
    int         s_inj[16];
    int         bfm_idx = 0;
    bit         bfm_busy = 0;
    int         idle_cyc = 0;
    logic       done_q = 1'b0;
    logic [7:0] mon_e;
    res_t       mon_r;

    always #5 clk = ~clk;

    uart_script_engine #(
        .DATA_WIDTH(8), .TX_DEPTH(TXD), .EXP_DEPTH(EXD),
        .GAP_CYCLES(GAP), .TIMEOUT(TMO), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .tx_len(tx_len), .exp_len(exp_len), .start(start),
        .uart_tx_ready(uart_tx_ready), .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data),
        .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_err(uart_rx_err),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .rx_count(rx_count)
    );

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT presents a tx byte or finishes a run.
    always @(negedge clk) begin
        if (uart_tx_valid) begin
            checks++;
            if (tx_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tx_pulse: got byte %02h, required no pulse", uart_tx_data);
            end else begin
                mon_e = tx_q.pop_front();
                if (uart_tx_data != mon_e) begin
                    errors++;
                    $display("FAIL tx_byte: got %02h, required %02h", uart_tx_data, mon_e);
                end
            end
        end
        if (done && !done_q) begin
            checks++;
            if (res_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1, required no run pending");
            end else begin
                checks--;
                mon_r = res_q.pop_front();
                chk("err_count", err_count, mon_r.err);
                chk("rx_count", rx_count, mon_r.rx);
                chk("pass", pass, mon_r.pass);
                chk("timeout", timeout, mon_r.tmo);
                chk("busy_at_done", busy, 0);
                if (mon_r.tmo) chk_rng("timeout_delay", idle_cyc, TMO - 1, TMO + 1);
            end
        end
        done_q = done;
        if (uart_tx_valid || uart_rx_valid || (start && !busy)) idle_cyc = 0;
        else idle_cyc++;
    end

    // Loopback BFM: each accepted byte drops ready, comes back on rx, then ready returns.
    initial begin : bfm
        logic [7:0] b;
        int k;
        uart_tx_ready = 1'b1;
        uart_rx_valid = 1'b0;
        uart_rx_err   = 1'b0;
        uart_rx_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (uart_tx_valid) begin
                b = uart_tx_data;
                k = (bfm_idx < 16) ? bfm_idx : 15;
                bfm_idx++;
                bfm_busy = 1;
                @(posedge clk); #1;
                uart_tx_ready = 1'b0;
                repeat ($urandom_range(4, 1)) begin @(posedge clk); #1; end
                if (s_inj[k] == 2) begin
                    uart_rx_err = 1'b1;
                    @(posedge clk); #1;
                    uart_rx_err = 1'b0;
                end
                uart_rx_valid = 1'b1;
                uart_rx_data  = b ^ s_mask[k];
                uart_rx_err   = (s_inj[k] == 1);
                @(posedge clk); #1;
                uart_rx_valid = 1'b0;
                uart_rx_err   = 1'b0;
                repeat ($urandom_range(3, 1)) begin @(posedge clk); #1; end
                uart_tx_ready = 1'b1;
                bfm_busy = 0;
            end
        end
    end

    task automatic write_scripts();
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            wr_en   = 1'b1;
            wr_sel  = (i >= 16);
            wr_addr = 4'(i % 16);
            wr_data = (i >= 16) ? s_exp[i - 16] : s_tx[i];
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_bfm_idle();
        int n = 0;
        while (bfm_busy && n < 500) begin @(posedge clk); #1; n++; end
        chk("bfm_idle_before_start", bfm_busy, 0);
    endtask

    task automatic pulse_start(input int txl_in, input int expl_in);
        @(posedge clk); #1;
        tx_len  = 5'(txl_in);
        exp_len = 5'(expl_in);
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Expected outcome from the script rules: every sent byte loops back before tx ready returns.
    task automatic run_case(input int txl_in, input int expl_in, input bit pokes);
        int   txl, expl, e, n;
        res_t r;
        logic [7:0] b;
        txl  = (txl_in > TXD) ? TXD : txl_in;
        expl = (expl_in > EXD) ? EXD : expl_in;
        e = 0;
        for (int i = 0; i < txl; i++) begin
            b = s_tx[i] ^ s_mask[i];
            if (i >= expl || b != s_exp[i]) e++;
            if (s_inj[i] != 0) e++;
        end
        r.err  = 16'(e);
        r.rx   = 16'(txl);
        r.tmo  = (txl < expl);
        r.pass = (e == 0) && !r.tmo && (txl == expl);
        write_scripts();
        wait_bfm_idle();
        for (int i = 0; i < txl; i++) tx_q.push_back(s_tx[i]);
        res_q.push_back(r);
        bfm_idx = 0;
        pulse_start(txl_in, expl_in);
        n = 0;
        if (txl > 0) begin
            @(negedge clk);
            n = 1;
            chk("start_to_tx_latency", uart_tx_valid, 1);
        end
        if (pokes && txl >= 2) begin
            @(posedge clk); #1;
            start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0;
            wr_addr = 4'(txl - 1); wr_data = ~s_tx[txl - 1];
            @(posedge clk); #1;
            start = 1'b0; wr_en = 1'b0;
            n = 0;
        end
        while (!done && n < 3000) begin @(negedge clk); n++; end
        if (!done) begin
            errors++; checks++;
            $display("FAIL run_done: got no done after %0d cycles, required done", n);
            @(posedge clk); #1; rst = 1'b1;
            @(posedge clk); #1; rst = 1'b0;
            tx_q.delete(); res_q.delete();
        end else begin
            if (txl == 0 && expl == 0) chk_rng("zero_len_done_cycles", n, 1, 3);
            repeat (2) @(negedge clk);
            chk("tx_pulses_remaining", tx_q.size(), 0);
        end
    endtask

    task automatic load_case1();
        for (int i = 0; i < 16; i++) begin
            s_tx[i] = 8'($urandom); s_exp[i] = 8'($urandom); s_inj[i] = 0; s_mask[i] = 8'h00;
        end
        s_tx[0] = 8'h41; s_tx[1] = 8'h71; s_tx[2] = 8'h0A;
        s_exp[0] = 8'h41; s_exp[1] = 8'h71; s_exp[2] = 8'h0A;
    endtask

    initial begin : driver
        int n, txl, expl, r;
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        tx_len = '0; exp_len = '0; start = 1'b0;
        for (int i = 0; i < 16; i++) begin s_inj[i] = 0; s_mask[i] = 8'h00; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {uart_tx_valid, uart_tx_data, busy, done, pass, timeout, err_count, rx_count}, 0);
        @(posedge clk); #1; rst = 1'b0;

        load_case1();   run_case(3, 3, 0);
        s_exp[1] = 8'h72; run_case(3, 3, 0);
        s_exp[1] = 8'h71; run_case(3, 4, 0);
        run_case(3, 2, 0);
        s_inj[1] = 2;   run_case(3, 3, 0);
        s_inj[1] = 1;   run_case(3, 3, 0);
        s_inj[1] = 0;   run_case(0, 0, 0);

        // Abort between the first and second tx byte.
        write_scripts();
        wait_bfm_idle();
        tx_q.push_back(8'h41);
        bfm_idx = 0;
        pulse_start(3, 3);
        n = 0;
        while (!uart_tx_valid && n < 100) begin @(negedge clk); n++; end
        chk("first_pulse_before_abort", uart_tx_valid, 1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_outputs", {uart_tx_valid, uart_tx_data, busy, done, pass, timeout, err_count, rx_count}, 0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("abort_tx_queue", tx_q.size(), 0);
        run_case(3, 3, 1);

        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 16; i++) begin
                s_tx[i]  = 8'($urandom);
                s_exp[i] = ($urandom_range(99, 0) < 85) ? s_tx[i] : 8'($urandom);
                r = $urandom_range(99, 0);
                s_inj[i]  = (r < 6) ? 1 : (r < 12) ? 2 : 0;
                s_mask[i] = ($urandom_range(99, 0) < 8) ? 8'($urandom_range(255, 1)) : 8'h00;
            end
            txl  = $urandom_range(20, 0);
            expl = ($urandom_range(2, 0) != 0) ? txl : $urandom_range(20, 0);
            run_case(txl, expl, ($urandom_range(2, 0) == 0));
        end

        repeat (20) @(negedge clk);
        chk("res_queue_drained", res_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: got no end of test, required finish");
        $fatal(1);
    end

endmodule
